// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_pkg;

    localparam int SAR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } sar_state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } sar_flags_t;

endpackage

// File: rtl/sar_flag_check.sv
// Comparator flag decode: legal when exactly one flag is high, keep when the trial bit survives.
module sar_flag_check
    import sar_pkg::*;
(
    input  sar_flags_t flags,
    output logic       legal,
    output logic       keep
);

    // Odd parity with not-all-three-set is exactly "one hot" for three bits.
    assign legal = (flags.gt ^ flags.lt ^ flags.eq) & ~(flags.gt & flags.lt & flags.eq);
    assign keep  = flags.lt | flags.eq;

endmodule

// File: rtl/sar_search16.sv
// SAR search controller resolving a hidden operand from gt/lt/eq compare flags, MSB first.
// Optional build macro SAR_EARLY_EXIT_EN: a legal eq ends the search immediately.
module sar_search16
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_BIT = ONE << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    sar_state_e       state_r;
    logic [WIDTH-1:0] acc_r;
    logic [IDX_W-1:0] bit_idx_r;
    sar_flags_t       flags_s;
    logic             legal_s;
    logic             keep_s;
    logic             early_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] trial_next_s;

    assign flags_s = {cmp_gt, cmp_lt, cmp_eq};

    sar_flag_check u_flag_check (
        .flags (flags_s),
        .legal (legal_s),
        .keep  (keep_s)
    );

`ifdef SAR_EARLY_EXIT_EN
    assign early_s = flags_s.eq;
`else
    assign early_s = 1'b0;
`endif

    // Next accumulator and next trial for the current compare outcome.
    always_comb begin
        acc_next_s   = acc_r;
        trial_next_s = trial;
        if (keep_s) begin
            acc_next_s = trial;
        end else begin
            acc_next_s = acc_r;
        end
        if (bit_idx_r != IDX_ZERO) begin
            trial_next_s = acc_next_s | (ONE << (bit_idx_r - IDX_ONE));
        end else begin
            trial_next_s = trial;
        end
    end

    // Search FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            acc_r     <= {WIDTH{1'b0}};
            bit_idx_r <= IDX_TOP;
            trial     <= {WIDTH{1'b0}};
            result    <= {WIDTH{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= ST_SEARCH;
                        busy      <= 1'b1;
                        acc_r     <= {WIDTH{1'b0}};
                        bit_idx_r <= IDX_TOP;
                        trial     <= MSB_BIT;
                        err       <= 1'b0;
                        found     <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (!legal_s) begin
                        // Protocol violation: report whatever was resolved so far.
                        err     <= 1'b1;
                        result  <= acc_r;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        acc_r <= acc_next_s;
                        if (flags_s.eq) begin
                            found <= 1'b1;
                        end
                        if (early_s || (bit_idx_r == IDX_ZERO)) begin
                            result  <= acc_next_s;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            bit_idx_r <= bit_idx_r - IDX_ONE;
                            trial     <= trial_next_s;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
